fifo_stream_reader: RTL and testbench

- Drain-side controller for the team's synchronous FIFO (1-cycle registered read, active-high `r_en`, `empty` flag).
- Pops words from the FIFO and presents them on a valid/ready stream output.
- Uses a 2-entry output buffer to give back-to-back throughput under backpressure.
- Sits between a FIFO read port and any downstream consumer.

---
 rtl/fifo_stream_reader_if.sv | 32 +++
 rtl/fifo_stream_reader.sv | 88 ++++++++
 tb/tb_fifo_stream_reader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between a FIFO read port, the stream reader and its consumer.
// master = the reader (drives fifo_r_en, m_valid, m_data); slave = the FIFO/consumer side.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_r_en;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  // Stream side: a word transfers on any rising edge where m_valid && m_ready;
  // m_valid/m_data stay stable until that transfer happens.
  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_r_en,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    input  fifo_r_en,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream via a 2-entry skid buffer.
// Optional transfer counter rd_count is compiled in with `define READ_COUNT_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus,
`ifdef READ_COUNT_EN
  output logic [CNT_WIDTH-1:0] rd_count,
`endif
  output logic [1:0]           dbg_occ,
  output logic                 dbg_pend
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                  occ, occ_next;
  logic                  pend;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] head, tail, head_next, tail_next;
  logic                  pop;
  logic                  r_en;
  logic [2:0]            level;

  assign pop = valid_q && bus.m_ready;

  always_comb begin
    occ_next  = occ;
    head_next = head;
    tail_next = tail;
    // Words held after this edge: buffered + in flight - leaving.
    level = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    r_en  = !rst && !bus.fifo_empty && (level < 3'd2);

    case (level)
      3'd0:    occ_next = EMPTY;
      3'd1:    occ_next = ONE;
      default: occ_next = TWO;
    endcase

    if (pop && occ == TWO) head_next = tail;
    // The captured word lands in whichever slot is first free after the pop.
    if (pend) begin
      if (level == 3'd1) head_next = bus.fifo_rdata;
      else               tail_next = bus.fifo_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ     <= EMPTY;
      pend    <= 1'b0;
      valid_q <= 1'b0;
      head    <= '0;
      tail    <= '0;
    end else begin
      occ     <= occ_next;
      pend    <= r_en;
      valid_q <= (occ_next != EMPTY);
      head    <= head_next;
      tail    <= tail_next;
    end
  end

  assign bus.fifo_r_en = r_en;
  assign bus.m_valid   = valid_q;
  assign bus.m_data    = head;
  assign dbg_occ       = occ;
  assign dbg_pend      = pend;

`ifdef READ_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)      rd_count <= '0;
    else if (pop) rd_count <= rd_count + 1'b1;
  end
`else
  // Keeps CNT_WIDTH referenced when the counter is compiled out.
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model + in-order scoreboard with per-word availability times.
module tb_fifo_stream_reader;
  localparam int W  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(W)) bus ();
  logic [1:0] dbg_occ;
  logic       dbg_pend;
`ifdef READ_COUNT_EN
  logic [CW-1:0] rd_count;
`endif

  fifo_stream_reader #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
`ifdef READ_COUNT_EN
    .rd_count (rd_count),
`endif
    .dbg_occ  (dbg_occ),
    .dbg_pend (dbg_pend)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [W-1:0] fifo_q[$];   // contents of the modelled FIFO
  logic [W-1:0] exp_q[$];    // words read from the FIFO, not yet delivered
  int           avail_q[$];  // first cycle each exp_q word may be presented
  logic [W-1:0] pop_log[$];
  int           pop_cyc[$];
  int           ren_cyc[$];
  int           ren_cnt, pop_cnt;
  logic         obs_ren, obs_valid, obs_pend;
  logic [1:0]   obs_occ;
  logic [W-1:0] obs_data;

  task automatic clear_logs();
    pop_log.delete(); pop_cyc.delete(); ren_cyc.delete();
    ren_cnt = 0; pop_cnt = 0;
  endtask

  // One clock cycle: drive at negedge, score at negedge+1, update FIFO model after posedge.
  task automatic step(input logic rdy, input logic rst_v);
    logic exp_valid, exp_pop, exp_ren, empty_v;
    @(negedge clk);
    rst = rst_v;
    bus.m_ready = rdy;
    empty_v = (fifo_q.size() == 0);
    bus.fifo_empty = empty_v;
    #1;
    obs_ren = bus.fifo_r_en; obs_valid = bus.m_valid; obs_data = bus.m_data;
    obs_occ = dbg_occ; obs_pend = dbg_pend;
    exp_valid = (exp_q.size() > 0) && (avail_q[0] <= cyc);
    exp_pop   = exp_valid && rdy;
    exp_ren   = !rst_v && !empty_v && ((exp_q.size() - int'(exp_pop)) < 2);
    tests_run++;
    if (obs_valid !== exp_valid) begin
      tests_failed++;
      $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid);
    end
    tests_run++;
    if (obs_ren !== exp_ren) begin
      tests_failed++;
      $display("FAIL fifo_r_en cyc=%0d got=%b exp=%b", cyc, obs_ren, exp_ren);
    end
    if (exp_valid) begin
      tests_run++;
      if (obs_data !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL m_data cyc=%0d got=%h exp=%h", cyc, obs_data, exp_q[0]);
      end
    end
    if (obs_ren === 1'b1) begin ren_cnt++; ren_cyc.push_back(cyc); end
    if (obs_valid === 1'b1 && rdy) begin
      pop_log.push_back(obs_data); pop_cyc.push_back(cyc); pop_cnt++;
    end
    if (exp_pop) begin void'(exp_q.pop_front()); void'(avail_q.pop_front()); end
    @(posedge clk);
    #1;
    if (obs_ren === 1'b1 && fifo_q.size() > 0) begin
      bus.fifo_rdata = fifo_q.pop_front();
      if (!rst_v) begin exp_q.push_back(bus.fifo_rdata); avail_q.push_back(cyc + 2); end
    end else begin
      bus.fifo_rdata = W'($urandom);
    end
    if (rst_v) begin exp_q.delete(); avail_q.delete(); end
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0) && n < 60) begin
      step(1'b1, 1'b0);
      n++;
    end
    tests_run++;
    if (fifo_q.size() > 0 || exp_q.size() > 0) begin
      tests_failed++;
      $display("FAIL drain_timeout fifo_left=%0d buffered=%0d exp=0", fifo_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) fifo_q.push_back(W'($urandom_range(0, 15)));
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1);
      tests_run++;
      if (obs_data !== '0) begin
        tests_failed++;
        $display("FAIL reset_m_data got=%h exp=0", obs_data);
      end
    end
    step(1'b1, 1'b0);
    tests_run++;
    if (obs_ren !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_read_after_reset got=%b exp=1", obs_ren);
    end
    drain();
  endtask

  task automatic test_streaming();
    clear_logs();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(W'(i));
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    drain();
    tests_run++;
    if (ren_cnt != 8) begin
      tests_failed++; $display("FAIL stream_read_count got=%0d exp=8", ren_cnt);
    end
    tests_run++;
    if (pop_cnt != 8) begin
      tests_failed++; $display("FAIL stream_pop_count got=%0d exp=8", pop_cnt);
    end else begin
      tests_run++;
      if (pop_cyc[0] != ren_cyc[0] + 2) begin
        tests_failed++;
        $display("FAIL stream_latency got=%0d exp=2", pop_cyc[0] - ren_cyc[0]);
      end
      tests_run++;
      if (pop_cyc[7] - pop_cyc[0] != 7) begin
        tests_failed++;
        $display("FAIL stream_no_bubbles span=%0d exp=7", pop_cyc[7] - pop_cyc[0]);
      end
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (pop_log[i] !== W'(i + 1)) begin
          tests_failed++;
          $display("FAIL stream_order idx=%0d got=%h exp=%h", i, pop_log[i], W'(i + 1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    for (int i = 1; i <= 5; i++) fifo_q.push_back(W'(i));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    tests_run++;
    if (ren_cnt != 2) begin
      tests_failed++; $display("FAIL bp_read_count got=%0d exp=2", ren_cnt);
    end
    tests_run++;
    if (obs_valid !== 1'b1 || obs_data !== W'(1)) begin
      tests_failed++;
      $display("FAIL bp_hold got valid=%b data=%h exp valid=1 data=1", obs_valid, obs_data);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    drain();
    tests_run++;
    if (pop_log.size() != 5) begin
      tests_failed++; $display("FAIL bp_pop_count got=%0d exp=5", pop_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (pop_log[i] !== W'(i + 1)) begin
          tests_failed++;
          $display("FAIL bp_order idx=%0d got=%h exp=%h", i, pop_log[i], W'(i + 1));
        end
      end
    end
  endtask

  task automatic test_empty();
    clear_logs();
    for (int i = 0; i < 3; i++) fifo_q.push_back(W'($urandom_range(0, 15)));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    tests_run++;
    if (ren_cnt != 3 || obs_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_drain got reads=%0d valid=%b exp reads=3 valid=0", ren_cnt, obs_valid);
    end
    fifo_q.push_back(W'(4'hA));
    step(1'b1, 1'b0);
    tests_run++;
    if (obs_ren !== 1'b1) begin
      tests_failed++; $display("FAIL empty_refill_read got=%b exp=1", obs_ren);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    tests_run++;
    if (obs_valid !== 1'b1 || obs_data !== W'(4'hA)) begin
      tests_failed++;
      $display("FAIL empty_refill_out got valid=%b data=%h exp valid=1 data=a", obs_valid, obs_data);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    clear_logs();
    fifo_q.push_back(W'(1)); fifo_q.push_back(W'(7)); fifo_q.push_back(W'(9));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    // Deepest reachable fill: one word buffered, 0x7 in flight on fifo_rdata.
    step(1'b0, 1'b1);
    tests_run++;
    if (obs_occ !== 2'd1 || obs_pend !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_setup got occ=%0d pend=%b exp occ=1 pend=1", obs_occ, obs_pend);
    end
    clear_logs();
    step(1'b1, 1'b0);
    tests_run++;
    if (obs_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_valid got=%b exp=0", obs_valid);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    drain();
    tests_run++;
    if (pop_log.size() != 1 || pop_log[0] !== W'(9)) begin
      tests_failed++;
      $display("FAIL midrst_resume got n=%0d first=%h exp n=1 first=9", pop_log.size(),
               (pop_log.size() > 0) ? pop_log[0] : W'(0));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] sent_q[$];
    logic [W-1:0] w;
    int bad = 0;
    clear_logs();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        w = W'($urandom);
        fifo_q.push_back(w); sent_q.push_back(w);
      end
      step(($urandom_range(0, 3) != 0), 1'b0);
    end
    drain();
    tests_run++;
    if (pop_log.size() != sent_q.size()) begin
      tests_failed++;
      $display("FAIL random_count got=%0d exp=%0d", pop_log.size(), sent_q.size());
    end else begin
      foreach (sent_q[i]) if (pop_log[i] !== sent_q[i]) bad++;
      tests_run++;
      if (bad != 0) begin
        tests_failed++; $display("FAIL random_order wrong_words=%0d exp=0", bad);
      end
    end
  endtask

`ifdef READ_COUNT_EN
  task automatic test_counter();
    step(1'b1, 1'b1);
    tests_run++;
    if (rd_count !== '0) begin
      tests_failed++; $display("FAIL cnt_reset got=%0d exp=0", rd_count);
    end
    for (int i = 0; i < 8; i++) fifo_q.push_back(W'($urandom));
    drain();
    tests_run++;
    if (rd_count !== CW'(8)) begin
      tests_failed++; $display("FAIL cnt_8 got=%0d exp=8", rd_count);
    end
    for (int i = 0; i < 9; i++) fifo_q.push_back(W'($urandom));
    drain();
    tests_run++;
    if (rd_count !== CW'(1)) begin
      tests_failed++; $display("FAIL cnt_wrap got=%0d exp=1", rd_count);
    end
    step(1'b1, 1'b1);
    tests_run++;
    if (rd_count !== '0) begin
      tests_failed++; $display("FAIL cnt_rst_again got=%0d exp=0", rd_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty();
    test_mid_reset();
    test_random();
`ifdef READ_COUNT_EN
    test_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
